dircc_debug_slave_sysclk_mc: RTL and testbench
==============================================

DIRCC_DEBUG_SLAVE_SYSCLK_MC -- requirements
Module: dircc_debug_slave_sysclk_mc

Interface
REQ-001 SHALL have parameters: SR_W, default 38, JTAG shift-register width (SHALL be >= 38); IR_W, default 2, virtual-JTAG IR width (SHALL be >= 2); N_CH, default 2, number of CPU debug channels (1..16); SYNC_STAGES, default 2, synchronizer depth (2..4).
REQ-002 SHALL derive CH_W = max(1, clog2(N_CH)) as a localparam.
REQ-003 SHALL have one clock and a synchronous, active-low reset: clk (in, 1) is the system clock, and reset_n (in, 1) is the synchronous active-low reset.
REQ-004 Ports:
  ir_in (in, IR_W): IR from the TCK domain; stable while vs_uir is high.
  ch_sel (in, CH_W): target channel from the TCK domain; stable while vs_uir is high.
  sr (in, SR_W): shift register from the TCK domain; stable while vs_udr is high.
  vs_uir, vs_udr (in, 1): update-IR / update-DR levels, asynchronous to clk.
  ch_en (in, N_CH): per-channel enable mask, clk domain.
  jdo (out, SR_W): captured data.
  take_action_ocimem_a, take_action_ocimem_b, take_no_action_ocimem_a, take_action_break_a/b/c, take_no_action_break_a/b/c, take_action_tracectrl (out, N_CH each): one-hot per-channel strobes.
  bad_sel (out, 1): sticky flag, illegal channel selected.
  drop_cnt (out, 8): saturating count of suppressed actions.
  act_cnt (out, 16): wrapping count of issued actions.

Function
REQ-005 vs_uir and vs_udr SHALL each pass through a SYNC_STAGES-flop synchronizer plus one delay flop; rise = last stage AND NOT delay flop, lasting one clk cycle.
REQ-006 On a uir rise: ir_sys <= ir_in and ch_sys <= ch_sel. If ch_sel >= N_CH, bad_sel SHALL be set to 1 and held until reset.
REQ-007 On a udr rise: jdo <= sr and pend <= 1. jdo SHALL hold its value otherwise. pend SHALL clear on the following edge.
REQ-008 If uir and udr rise in the same cycle, ir_sys and ch_sys SHALL update on that edge and SHALL be used by the resulting decode.
REQ-009 With pend=1, the decode SHALL be registered so that exactly one strobe bit is high for exactly one cycle, in bit ch_sys, on the edge after jdo loads.
  Total latency is SYNC_STAGES+2 clk edges from the first edge that samples vs_udr high.
REQ-010 Decode, using ir = ir_sys[1:0] and j = jdo:
  ir=0: take_action_ocimem_a = !j[35] & j[34]; take_no_action_ocimem_a = !j[35] & !j[34]; take_action_ocimem_b = j[35].
  ir=2: take_action_break_a = !j[36] & j[37]; take_no_action_break_a = !j[36] & !j[37]; take_action_break_b = j[36] & !j[35] & j[37]; take_no_action_break_b = j[36] & !j[35] & !j[37]; take_action_break_c = j[36] & j[35] & j[37]; take_no_action_break_c = j[36] & j[35] & !j[37].
  ir=3: take_action_tracectrl = j[15].
  ir=1, or IR_W > 2 with ir_sys[IR_W-1:2] != 0: no strobe, and counters unchanged.
REQ-011 Suppression: if a decode would fire but ch_sys >= N_CH or ch_en[ch_sys]=0, all strobes SHALL stay 0 and drop_cnt SHALL increment, saturating at 255.
REQ-012 Each strobe actually issued SHALL increment act_cnt by 1, wrapping from 65535 to 0.
REQ-013 A udr rise while pend=1 is impossible, because a rise needs two cycles; no queuing is required.
REQ-014 All outputs SHALL be registered. No combinational path SHALL exist from any input to any output.

Reset
REQ-015 While reset_n=0 at a clk edge, all of the following SHALL be cleared to 0: synchronizer flops, delay flops, ir_sys, ch_sys, jdo, pend, all strobes, bad_sel, drop_cnt and act_cnt.
REQ-016 Reset asserted mid-operation (pend=1, or a synchronizer holding 1) SHALL cancel the pending strobe; no strobe SHALL appear after reset releases.
REQ-017 If vs_udr is already high when reset releases, it SHALL produce exactly one rise, SYNC_STAGES+1 edges later.

Verification
REQ-018 OCI write: ch_sel=1, ir_in=0, uir pulse; sr[35:34]=2'b01, udr pulse, ch_en=2'b11 -> jdo=sr; take_action_ocimem_a=2'b10 for 1 cycle at edge SYNC_STAGES+2; act_cnt=1.
REQ-019 Break decode: ir=2 on ch0, sr[37:35]=3'b110 -> take_action_break_b=2'b01; repeat with sr[37:35]=3'b011 -> take_no_action_break_c=2'b01; all other strobes stay 0.
REQ-020 Disabled or illegal channel: ch_en=2'b01, ch_sel=1, ir=3, sr[15]=1 -> no strobe, drop_cnt=1. Then N_CH=3, ch_sel=3 -> bad_sel=1 and stays 1 after later legal commands.
REQ-021 Simultaneous and saturating events: uir and udr rise on the same edge with ir_in changing from 0 to 3 -> decode uses ir=3. Then 300 suppressed actions -> drop_cnt=255.
REQ-022 Reset mid-flight: reset_n=0 on the jdo-load edge -> no strobe, jdo=0, act_cnt=0. vs_udr held high through the reset release -> exactly one strobe.

Source files
------------

// File: rtl/dircc_debug_slave_sysclk_mc.sv
// rtl/dircc_debug_slave_sysclk_mc.sv - system-clock side of the virtual-JTAG CPU debug slave.
// Synchronizes update-IR/update-DR, captures IR/channel/data, and issues registered one-hot strobes.
module dircc_debug_slave_sysclk_mc #(
    parameter int SR_W        = 38,
    parameter int IR_W        = 2,
    parameter int N_CH        = 2,
    parameter int SYNC_STAGES = 2,
    localparam int CH_W       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [IR_W-1:0]   ir_in,
    input  logic [CH_W-1:0]   ch_sel,
    input  logic [SR_W-1:0]   sr,
    input  logic              vs_uir,
    input  logic              vs_udr,
    input  logic [N_CH-1:0]   ch_en,
    output logic [SR_W-1:0]   jdo,
    output logic [N_CH-1:0]   take_action_ocimem_a,
    output logic [N_CH-1:0]   take_action_ocimem_b,
    output logic [N_CH-1:0]   take_no_action_ocimem_a,
    output logic [N_CH-1:0]   take_action_break_a,
    output logic [N_CH-1:0]   take_action_break_b,
    output logic [N_CH-1:0]   take_action_break_c,
    output logic [N_CH-1:0]   take_no_action_break_a,
    output logic [N_CH-1:0]   take_no_action_break_b,
    output logic [N_CH-1:0]   take_no_action_break_c,
    output logic [N_CH-1:0]   take_action_tracectrl,
    output logic              bad_sel,
    output logic [7:0]        drop_cnt,
    output logic [15:0]       act_cnt
);

    localparam logic [CH_W:0]   N_CH_L = (CH_W + 1)'(N_CH);
    localparam logic [N_CH-1:0] ONE    = N_CH'(1);

    logic [SYNC_STAGES-1:0] uir_sync;
    logic [SYNC_STAGES-1:0] udr_sync;
    logic                   uir_dly;
    logic                   udr_dly;
    logic                   uir_rise;
    logic                   udr_rise;
    logic [IR_W-1:0]        ir_sys;
    logic [CH_W-1:0]        ch_sys;
    logic                   pend;
    logic [9:0]             hit;
    logic                   ir_hi_zero;
    logic                   ch_ok;
    logic [N_CH-1:0]        onehot;
    logic [N_CH-1:0]        strb [10];

    assign uir_rise   = uir_sync[SYNC_STAGES-1] & ~uir_dly;
    assign udr_rise   = udr_sync[SYNC_STAGES-1] & ~udr_dly;
    assign ir_hi_zero = ((ir_sys >> 2) == '0);
    assign ch_ok      = ({1'b0, ch_sys} < N_CH_L) && ch_en[ch_sys];
    assign onehot     = ONE << ch_sys;

    // Strobe index order: ocimem_a, ocimem_b, no_ocimem_a, break_a/b/c, no_break_a/b/c, tracectrl
    always_comb begin
        hit = '0;
        if (ir_hi_zero) begin
            case (ir_sys[1:0])
                2'd0: begin
                    hit[0] = ~jdo[35] &  jdo[34];
                    hit[1] =  jdo[35];
                    hit[2] = ~jdo[35] & ~jdo[34];
                end
                2'd2: begin
                    hit[3] = ~jdo[36] &  jdo[37];
                    hit[4] =  jdo[36] & ~jdo[35] &  jdo[37];
                    hit[5] =  jdo[36] &  jdo[35] &  jdo[37];
                    hit[6] = ~jdo[36] & ~jdo[37];
                    hit[7] =  jdo[36] & ~jdo[35] & ~jdo[37];
                    hit[8] =  jdo[36] &  jdo[35] & ~jdo[37];
                end
                2'd3: hit[9] = jdo[15];
                default: hit = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            uir_sync <= '0;
            udr_sync <= '0;
            uir_dly  <= 1'b0;
            udr_dly  <= 1'b0;
            ir_sys   <= '0;
            ch_sys   <= '0;
            jdo      <= '0;
            pend     <= 1'b0;
            bad_sel  <= 1'b0;
            drop_cnt <= '0;
            act_cnt  <= '0;
            for (int i = 0; i < 10; i++) strb[i] <= '0;
        end else begin
            uir_sync <= {uir_sync[SYNC_STAGES-2:0], vs_uir};
            udr_sync <= {udr_sync[SYNC_STAGES-2:0], vs_udr};
            uir_dly  <= uir_sync[SYNC_STAGES-1];
            udr_dly  <= udr_sync[SYNC_STAGES-1];
            if (uir_rise) begin
                ir_sys <= ir_in;
                ch_sys <= ch_sel;
                if ({1'b0, ch_sel} >= N_CH_L) bad_sel <= 1'b1;
            end
            if (udr_rise) jdo <= sr;
            pend <= udr_rise;
            for (int i = 0; i < 10; i++) strb[i] <= '0;
            // A decode that selects nothing (ir=1, unset tracectrl bit) neither fires nor counts as a drop
            if (pend && (|hit)) begin
                if (ch_ok) begin
                    for (int i = 0; i < 10; i++) begin
                        if (hit[i]) strb[i] <= onehot;
                    end
                    act_cnt <= act_cnt + 16'd1;
                end else if (drop_cnt != 8'hff) begin
                    drop_cnt <= drop_cnt + 8'd1;
                end
            end
        end
    end

    assign take_action_ocimem_a    = strb[0];
    assign take_action_ocimem_b    = strb[1];
    assign take_no_action_ocimem_a = strb[2];
    assign take_action_break_a     = strb[3];
    assign take_action_break_b     = strb[4];
    assign take_action_break_c     = strb[5];
    assign take_no_action_break_a  = strb[6];
    assign take_no_action_break_b  = strb[7];
    assign take_no_action_break_c  = strb[8];
    assign take_action_tracectrl   = strb[9];

endmodule

// File: tb/tb_dircc_debug_slave_sysclk_mc.sv
// tb/tb_dircc_debug_slave_sysclk_mc.sv - randomized bench with a cycle-level behavioural model.
module tb_dircc_debug_slave_sysclk_mc;

    localparam int S   = 2;
    localparam int NC  = 3;
    localparam int IRW = 3;
    localparam int SRW = 38;
    localparam int CW  = 2;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic [IRW-1:0]  ir_in = '0;
    logic [CW-1:0]   ch_sel = '0;
    logic [SRW-1:0]  sr = '0;
    logic            vs_uir = 1'b0;
    logic            vs_udr = 1'b0;
    logic [NC-1:0]   ch_en = '0;
    logic [SRW-1:0]  jdo;
    logic [NC-1:0]   dut_strb [10];
    logic            bad_sel;
    logic [7:0]      drop_cnt;
    logic [15:0]     act_cnt;

    always #5 clk = ~clk;

    dircc_debug_slave_sysclk_mc #(.SR_W(SRW), .IR_W(IRW), .N_CH(NC), .SYNC_STAGES(S)) dut (
        .clk(clk), .reset_n(reset_n), .ir_in(ir_in), .ch_sel(ch_sel), .sr(sr),
        .vs_uir(vs_uir), .vs_udr(vs_udr), .ch_en(ch_en), .jdo(jdo),
        .take_action_ocimem_a(dut_strb[0]), .take_action_ocimem_b(dut_strb[1]),
        .take_no_action_ocimem_a(dut_strb[2]), .take_action_break_a(dut_strb[3]),
        .take_action_break_b(dut_strb[4]), .take_action_break_c(dut_strb[5]),
        .take_no_action_break_a(dut_strb[6]), .take_no_action_break_b(dut_strb[7]),
        .take_no_action_break_c(dut_strb[8]), .take_action_tracectrl(dut_strb[9]),
        .bad_sel(bad_sel), .drop_cnt(drop_cnt), .act_cnt(act_cnt)
    );

    int pass_cnt = 0;
    int total_cnt = 0;
    bit checking = 0;
    string sname [10] = '{"ocimem_a", "ocimem_b", "no_ocimem_a", "break_a", "break_b",
                          "break_c", "no_break_a", "no_break_b", "no_break_c", "tracectrl"};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        else pass_cnt++;
    endtask

    // Model: levels seen at each edge (0 while in reset), a rise is a high sample preceded by a low one
    bit          eff_u [0:65535];
    bit          eff_d [0:65535];
    int          k = -1;
    int          last_reset = -1;
    int          exp_ir = 0, exp_ch = 0, exp_act = 0, exp_drop = 0;
    bit          exp_bad = 0;
    logic [SRW-1:0] exp_jdo = '0;
    bit          pend_valid = 0;
    int          pend_kind = -1, pend_ch = 0;
    logic [NC-1:0] exp_strb [10] = '{default: '0};

    function automatic bit vu(input int n);
        return (n > last_reset && n >= 0) ? eff_u[n] : 1'b0;
    endfunction
    function automatic bit vd(input int n);
        return (n > last_reset && n >= 0) ? eff_d[n] : 1'b0;
    endfunction

    function automatic int kind_of(input int ir, input logic [SRW-1:0] j);
        case (ir)
            0: return j[35] ? 1 : (j[34] ? 0 : 2);
            2: begin
                if (!j[36]) return j[37] ? 3 : 6;
                if (!j[35]) return j[37] ? 4 : 7;
                return j[37] ? 5 : 8;
            end
            3: return j[15] ? 9 : -1;
            default: return -1;
        endcase
    endfunction

    always @(posedge clk) begin : model
        bit ur, dr;
        k++;
        eff_u[k] = reset_n & vs_uir;
        eff_d[k] = reset_n & vs_udr;
        for (int i = 0; i < 10; i++) exp_strb[i] = '0;
        if (!reset_n) begin
            last_reset = k;
            exp_ir = 0; exp_ch = 0; exp_jdo = '0; exp_act = 0; exp_drop = 0; exp_bad = 0;
            pend_valid = 0;
        end else begin
            if (pend_valid && pend_kind >= 0) begin
                if (pend_ch < NC && ch_en[pend_ch]) begin
                    exp_strb[pend_kind] = NC'(1 << pend_ch);
                    exp_act = (exp_act + 1) % 65536;
                end else if (exp_drop < 255) begin
                    exp_drop++;
                end
            end
            pend_valid = 0;
            ur = vu(k - S) && !vu(k - S - 1);
            dr = vd(k - S) && !vd(k - S - 1);
            if (ur) begin
                exp_ir = int'(ir_in);
                exp_ch = int'(ch_sel);
                if (exp_ch >= NC) exp_bad = 1;
            end
            if (dr) begin
                exp_jdo = sr;
                pend_valid = 1;
                pend_kind = kind_of(exp_ir, exp_jdo);
                pend_ch = exp_ch;
            end
        end
    end

    logic [NC-1:0] seen [10];
    int strobe_cycles = 0;

    always @(negedge clk) begin
        if (checking) begin
            chk("jdo", 64'(jdo), 64'(exp_jdo));
            for (int i = 0; i < 10; i++) chk(sname[i], 64'(dut_strb[i]), 64'(exp_strb[i]));
            chk("bad_sel", 64'(bad_sel), 64'(exp_bad));
            chk("drop_cnt", 64'(drop_cnt), 64'(exp_drop));
            chk("act_cnt", 64'(act_cnt), 64'(exp_act));
        end
        for (int i = 0; i < 10; i++) begin
            seen[i] = seen[i] | dut_strb[i];
            if (dut_strb[i] != '0) strobe_cycles++;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_seen();
        for (int i = 0; i < 10; i++) seen[i] = '0;
        strobe_cycles = 0;
    endtask

    function automatic logic [NC-1:0] seen_except(input int idx);
        logic [NC-1:0] acc;
        acc = '0;
        for (int i = 0; i < 10; i++) if (i != idx) acc = acc | seen[i];
        return acc;
    endfunction

    task automatic do_reset();
        reset_n = 1'b0; vs_uir = 1'b0; vs_udr = 1'b0;
        cyc(2);
        reset_n = 1'b1;
        cyc(1);
    endtask

    task automatic cmd(input int ir, input int ch, input logic [SRW-1:0] v, input bit simul);
        ir_in = IRW'(ir);
        ch_sel = CW'(ch);
        if (simul) begin
            sr = v; vs_uir = 1'b1; vs_udr = 1'b1;
            cyc(2);
            vs_uir = 1'b0; vs_udr = 1'b0;
        end else begin
            vs_uir = 1'b1; cyc(2); vs_uir = 1'b0; cyc(2);
            sr = v; vs_udr = 1'b1; cyc(2); vs_udr = 1'b0;
        end
        cyc(S + 4);
    endtask

    function automatic logic [SRW-1:0] rnd_sr();
        return {6'($urandom), 32'($urandom)};
    endfunction

    initial begin
        logic [SRW-1:0] v;
        clear_seen();
        cyc(2);
        checking = 1;
        chk("reset_act", 64'(act_cnt), 64'd0);
        chk("reset_jdo", 64'(jdo), 64'd0);

        // OCI write with exact strobe latency
        do_reset();
        ch_en = 3'b111;
        ir_in = '0; ch_sel = 2'd1; vs_uir = 1'b1; cyc(2); vs_uir = 1'b0; cyc(2);
        v = rnd_sr(); v[35:34] = 2'b01;
        sr = v; vs_udr = 1'b1;
        for (int e = 1; e <= S + 3; e++) begin
            @(posedge clk); #1;
            if (e == S + 1) begin
                chk("oci_jdo", 64'(jdo), 64'(v));
                chk("oci_early", 64'(dut_strb[0]), 64'd0);
            end
            if (e == S + 2) chk("oci_strobe", 64'(dut_strb[0]), 64'b010);
            if (e == S + 3) begin
                chk("oci_gone", 64'(dut_strb[0]), 64'd0);
                chk("oci_act", 64'(act_cnt), 64'd1);
            end
        end
        @(negedge clk); vs_udr = 1'b0; cyc(3);

        // Break decodes on channel 0
        clear_seen();
        v = rnd_sr(); v[37:35] = 3'b110;
        cmd(2, 0, v, 0);
        chk("break_b", 64'(seen[4]), 64'b001);
        chk("break_b_others", 64'(seen_except(4)), 64'd0);
        clear_seen();
        v = rnd_sr(); v[37:35] = 3'b011;
        cmd(2, 0, v, 0);
        chk("no_break_c", 64'(seen[8]), 64'b001);
        chk("no_break_c_others", 64'(seen_except(8)), 64'd0);

        // Disabled and illegal channels
        do_reset();
        ch_en = 3'b001; clear_seen();
        v = rnd_sr(); v[15] = 1'b1;
        cmd(3, 1, v, 0);
        chk("disabled_none", 64'(seen_except(-1)), 64'd0);
        chk("disabled_drop", 64'(drop_cnt), 64'd1);
        cmd(3, 3, v, 0);
        chk("illegal_bad", 64'(bad_sel), 64'd1);
        chk("illegal_drop", 64'(drop_cnt), 64'd2);
        ch_en = 3'b111;
        cmd(0, 0, v, 0);
        chk("bad_sticky", 64'(bad_sel), 64'd1);
        chk("legal_act", 64'(act_cnt), 64'd1);

        // Same-edge IR/DR updates, then drop saturation
        do_reset();
        ch_en = 3'b111;
        cmd(0, 0, rnd_sr(), 0);
        clear_seen();
        v = rnd_sr(); v[15] = 1'b1;
        cmd(3, 0, v, 1);
        chk("simul_trace", 64'(seen[9]), 64'b001);
        chk("simul_others", 64'(seen_except(9)), 64'd0);
        ch_en = 3'b000;
        repeat (300) cmd(3, 0, v, 1);
        chk("drop_sat", 64'(drop_cnt), 64'd255);

        // Reset on the load edge cancels everything
        do_reset();
        ch_en = 3'b111; clear_seen();
        v = rnd_sr(); sr = v; vs_udr = 1'b1;
        cyc(S);
        reset_n = 1'b0;
        cyc(1);
        reset_n = 1'b1; vs_udr = 1'b0;
        cyc(S + 5);
        chk("rst_none", 64'(seen_except(-1)), 64'd0);
        chk("rst_jdo", 64'(jdo), 64'd0);
        chk("rst_act", 64'(act_cnt), 64'd0);

        // vs_udr held high across reset release yields exactly one strobe
        clear_seen();
        vs_udr = 1'b1; cyc(2);
        reset_n = 1'b0; cyc(2);
        reset_n = 1'b1; cyc(S + 6);
        vs_udr = 1'b0; cyc(4);
        chk("held_one_strobe", 64'(strobe_cycles), 64'd1);

        // Randomized traffic including occasional resets
        for (int n = 0; n < 150; n++) begin
            ch_en = NC'($urandom);
            ir_in = IRW'($urandom_range(0, 7));
            ch_sel = CW'($urandom_range(0, 3));
            vs_uir = 1'b1;
            if ($urandom_range(0, 3) == 0) begin
                sr = rnd_sr(); vs_udr = 1'b1;
            end
            cyc($urandom_range(1, 3));
            vs_uir = 1'b0; vs_udr = 1'b0;
            cyc($urandom_range(0, 3));
            sr = rnd_sr(); vs_udr = 1'b1;
            for (int h = 0; h < 3; h++) begin
                reset_n = ($urandom_range(0, 24) != 0);
                cyc(1);
            end
            reset_n = 1'b1; vs_udr = 1'b0;
            cyc($urandom_range(1, S + 4));
        end
        cyc(S + 4);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
